// File: rtl/ddr5_phy_wrdata_crc_if.sv
// ----------------------------------------------------------------------------
// ddr5_phy_wrdata_crc_if
//   Beat-serial write-data bus around the write-CRC stage of one x4 DDR5 lane.
//   The upstream side (DFI write path) offers beats with in_valid_i/in_data_i
//   and sees in_ready_o; the downstream side (DQ serializer) receives
//   out_valid_o/out_data_o plus the out_crc_o and out_last_o beat markers.
//
//   Signals
//     in_valid_i   upstream beat valid
//     in_data_i    upstream beat, bit n = DQn
//     in_ready_o   stage accepts a beat when in_valid_i & in_ready_o
//     out_valid_o  out_data_o carries a valid beat
//     out_data_o   data or CRC beat to the serializer
//     out_crc_o    current out beat is a CRC beat
//     out_last_o   final beat of the burst
//
//   Modports
//     master  upstream driver / observer of the output side
//     slave   the CRC stage itself
// ----------------------------------------------------------------------------
interface ddr5_phy_wrdata_crc_if #(
    parameter int pDQ_WIDTH = 4
);
    logic                 in_valid_i;
    logic [pDQ_WIDTH-1:0] in_data_i;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic [pDQ_WIDTH-1:0] out_data_o;
    logic                 out_crc_o;
    logic                 out_last_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_crc_o,
        input  out_last_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_crc_o,
        output out_last_o
    );
endinterface

// File: rtl/ddr5_phy_wrdata_crc.sv
// ----------------------------------------------------------------------------
// ddr5_phy_wrdata_crc
//   Write-data CRC stage for one x4 DDR5 device lane, between the DFI
//   write-data path and the DQ serializer. A BL16 burst is forwarded with
//   one cycle of latency; when CRC mode is enabled two extra beats carrying
//   the CRC-8 (poly 0x07, MSB-first, no final XOR) are appended (BL18).
//   CRC bits are consumed beat 0..15, DQ0..DQ3 within each beat.
//
//   Ports
//     clk_i           PHY clock
//     rst_i           synchronous, active-high reset
//     phy_CRC_mode_i  1 = append CRC; sampled when beat 0 is accepted
//     bus             ddr5_phy_wrdata_crc_if.slave (in/out beat handshake)
// ----------------------------------------------------------------------------
module ddr5_phy_wrdata_crc #(
    parameter int         pDQ_WIDTH  = 4,
    parameter int         pBURST_LEN = 16,
    parameter logic [7:0] pCRC_INIT  = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  phy_CRC_mode_i,
    ddr5_phy_wrdata_crc_if.slave  bus
);

    localparam int             CNT_W     = $clog2(pBURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(pBURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC0 = 2'd2,
        CRC1 = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     beat_cnt;
    logic [7:0]           crc;
    logic                 crc_en;

    logic                 in_ready;
    logic                 accept;
    logic                 last_beat;
    logic                 first_beat;
    logic [7:0]           crc_upd;

    logic                 vld_p1;
    logic [pDQ_WIDTH-1:0] data_p1;
    logic                 crc_beat_p1;
    logic                 last_p1;

    // Applies one whole beat to the CRC, DQ0 first, in a single cycle.
    function automatic logic [7:0] crc8_beat(input logic [7:0]           crc_in,
                                             input logic [pDQ_WIDTH-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < pDQ_WIDTH; i++) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign in_ready   = (state == IDLE) || (state == DATA);
    assign accept     = bus.in_valid_i && in_ready;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    // Beat 0 restarts from the seed so a burst never inherits a stale CRC.
    assign crc_upd    = crc8_beat(first_beat ? pCRC_INIT : crc, bus.in_data_i);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = DATA;
            DATA: if (accept && last_beat) state_nxt = crc_en ? CRC0 : IDLE;
            CRC0: state_nxt = CRC1;
            CRC1: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0 -> p1: accept beat, update CRC, register output beat ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            crc         <= pCRC_INIT;
            crc_en      <= 1'b0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            crc_beat_p1 <= 1'b0;
            last_p1     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                crc      <= crc_upd;
                // Mode is latched per burst; later toggles wait for beat 0.
                if (first_beat) crc_en <= phy_CRC_mode_i;
            end

            vld_p1      <= accept || (state == CRC0) || (state == CRC1);
            crc_beat_p1 <= (state == CRC0) || (state == CRC1);
            // crc_en is still the current burst's value when beat 15 lands.
            last_p1     <= (accept && last_beat && !crc_en) || (state == CRC1);

            // out_data holds its last value whenever nothing new is emitted.
            if (accept)
                data_p1 <= bus.in_data_i;
            else if (state == CRC0)
                data_p1 <= crc[pDQ_WIDTH-1:0];
            else if (state == CRC1)
                data_p1 <= crc[2*pDQ_WIDTH-1:pDQ_WIDTH];
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p1;
    assign bus.out_data_o  = data_p1;
    assign bus.out_crc_o   = crc_beat_p1;
    assign bus.out_last_o  = last_p1;

endmodule

// File: tb/tb_ddr5_phy_wrdata_crc.sv
// ----------------------------------------------------------------------------
// tb_ddr5_phy_wrdata_crc
//   Directed bench for ddr5_phy_wrdata_crc. Inputs change and outputs are
//   sampled 1 time unit after the rising edge; expected CRCs are hand-derived.
// ----------------------------------------------------------------------------
module tb_ddr5_phy_wrdata_crc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ddr5_phy_wrdata_crc_if #(.pDQ_WIDTH(4)) bus ();

    ddr5_phy_wrdata_crc #(
        .pDQ_WIDTH (4),
        .pBURST_LEN(16),
        .pCRC_INIT (8'h00)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .phy_CRC_mode_i(mode),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                           input logic c, input logic l);
        chk({tag, ".valid"}, 8'(bus.out_valid_o), 8'(v));
        chk({tag, ".data"},  8'(bus.out_data_o),  8'(d));
        chk({tag, ".crc"},   8'(bus.out_crc_o),   8'(c));
        chk({tag, ".last"},  8'(bus.out_last_o),  8'(l));
    endtask

    // Offers one beat, which must be accepted this cycle, and checks its echo.
    task automatic beat(input string tag, input logic [3:0] d, input logic exp_last);
        chk({tag, ".ready"}, 8'(bus.in_ready_o), 8'h01);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        tick();
        bus.in_valid_i = 1'b0;
        chk_out(tag, 1'b1, d, 1'b0, exp_last);
    endtask

    task automatic idle(input string tag, input logic [3:0] hold_d);
        bus.in_valid_i = 1'b0;
        tick();
        chk_out(tag, 1'b0, hold_d, 1'b0, 1'b0);
    endtask

    // Called right after beat 15 was echoed: expects CRC0 then CRC1.
    task automatic crc_beats(input string tag, input logic [7:0] exp_crc);
        chk({tag, ".rdy_c0"}, 8'(bus.in_ready_o), 8'h00);
        tick();
        chk_out({tag, ".crc0"}, 1'b1, exp_crc[3:0], 1'b1, 1'b0);
        chk({tag, ".rdy_c1"}, 8'(bus.in_ready_o), 8'h00);
        tick();
        chk_out({tag, ".crc1"}, 1'b1, exp_crc[7:4], 1'b1, 1'b1);
        chk({tag, ".rdy_after"}, 8'(bus.in_ready_o), 8'h01);
    endtask

    // Zero burst except beats 14 and 15.
    task automatic burst(input string tag, input logic crc_on, input logic [3:0] b14,
                         input logic [3:0] b15, input logic [7:0] exp_crc);
        logic [3:0] d;
        mode = crc_on;
        for (int k = 0; k < 16; k++) begin
            d = (k == 15) ? b15 : (k == 14) ? b14 : 4'h0;
            beat($sformatf("%s.b%0d", tag, k), d, (k == 15) && !crc_on);
        end
        if (crc_on) crc_beats(tag, exp_crc);
    endtask

    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 4'h0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
        chk("reset.ready", 8'(bus.in_ready_o), 8'h01);
        rst = 1'b0;

        // 1: all-zero burst, CRC 00; then 2 and 3 back-to-back
        burst("s1", 1'b1, 4'h0, 4'h0, 8'h00);
        burst("s2", 1'b1, 4'h0, 4'b1000, 8'h07);
        burst("s3", 1'b1, 4'h0, 4'b0100, 8'h0E);
        // DQ3 on beat 14 then four zero bits: 0x07 shifted left by 4
        burst("s3b", 1'b1, 4'b1000, 4'h0, 8'h70);
        idle("s3b.idle", 4'h7);

        // 4: CRC off, two back-to-back bursts
        burst("s4a", 1'b0, 4'h0, 4'hA, 8'h00);
        burst("s4b", 1'b0, 4'h0, 4'h5, 8'h00);
        idle("s4.idle", 4'h5);

        // 5: gap after beat 7, mode toggled mid-burst
        mode = 1'b1;
        for (int k = 0; k < 8; k++) beat($sformatf("s5.b%0d", k), 4'h0, 1'b0);
        mode = 1'b0;
        for (int g = 0; g < 3; g++) begin
            idle($sformatf("s5.gap%0d", g), 4'h0);
            chk($sformatf("s5.gap%0d.ready", g), 8'(bus.in_ready_o), 8'h01);
        end
        for (int k = 8; k < 16; k++)
            beat($sformatf("s5.b%0d", k), (k == 15) ? 4'b1000 : 4'h0, 1'b0);
        crc_beats("s5", 8'h07);

        // 6: reset after beat 9, then a fresh burst
        mode = 1'b1;
        for (int k = 0; k < 10; k++)
            beat($sformatf("s6.b%0d", k), (k == 9) ? 4'b1010 : 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("s6.rst", 1'b0, 4'h0, 1'b0, 1'b0);
        chk("s6.rst.ready", 8'(bus.in_ready_o), 8'h01);
        idle("s6.post", 4'h0);
        burst("s6.fresh", 1'b1, 4'h0, 4'b0100, 8'h0E);
        idle("s6.end", 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
